// File: rtl/fetch_stage.sv
// Beta CPU instruction-fetch stage: PC, single-outstanding imem port,
// IF/ID register with one-entry hold buffer for decode stalls.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h83FF_F800
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ir_decode,
   output logic [31:0] pc_decode,
   output logic        valid_decode
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] addr_q;
   logic [31:0] hold_ir;
   logic [31:0] hold_pc;
   logic        req_hold;
   logic        hold_valid;
   logic        slot_free;
   logic        fire;
   logic        resp;
   logic        unused_pc_lsbs;

   function automatic logic [31:0] inc(
      input logic [31:0] a
   );
      return {a[31], a[30:0] + 31'd4};
   endfunction

   assign imem_addr      = pc;
   assign unused_pc_lsbs = ^redirect_pc[1:0];

   always_comb begin
      slot_free = (state == IDLE)
                | ((state != IDLE) & imem_rvalid);
      imem_req  = rst_n & ~redirect
                & (req_hold
                   | (slot_free & ~hold_valid & ~stall));
      fire      = imem_req & imem_gnt;
      resp      = (state == WAIT) & imem_rvalid;
      state_nxt = state;
      if (redirect) begin
         if (state == WAIT)
            state_nxt = imem_rvalid ? IDLE : DROP;
         else if (state == DROP && imem_rvalid)
            state_nxt = IDLE;
      end else if (fire) begin
         state_nxt = WAIT;
      end else if (state != IDLE && imem_rvalid) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         addr_q       <= '0;
         req_hold     <= 1'b0;
         hold_valid   <= 1'b0;
         hold_ir      <= '0;
         hold_pc      <= '0;
         ir_decode    <= NOP_INSTR;
         pc_decode    <= '0;
         valid_decode <= 1'b0;
      end else begin
         state    <= state_nxt;
         req_hold <= imem_req & ~imem_gnt;
         if (redirect) begin
            pc <= {redirect_pc[31:2], 2'b00};
         end else if (fire) begin
            addr_q <= pc;
            pc     <= inc(pc);
         end
         // A response landing during a stall parks in the hold buffer
         if (redirect) begin
            ir_decode    <= NOP_INSTR;
            pc_decode    <= '0;
            valid_decode <= 1'b0;
            hold_valid   <= 1'b0;
         end else if (stall) begin
            if (resp) begin
               hold_ir    <= imem_rdata;
               hold_pc    <= inc(addr_q);
               hold_valid <= 1'b1;
            end
         end else if (hold_valid) begin
            ir_decode    <= hold_ir;
            pc_decode    <= hold_pc;
            valid_decode <= 1'b1;
            hold_valid   <= 1'b0;
         end else if (resp) begin
            ir_decode    <= imem_rdata;
            pc_decode    <= inc(addr_q);
            valid_decode <= 1'b1;
         end else begin
            ir_decode    <= NOP_INSTR;
            pc_decode    <= '0;
            valid_decode <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory model plus
// transaction-level scoreboard of fetch addresses and IF/ID stream.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] NOP    = 32'h83FF_F800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] ir_decode;
   logic [31:0] pc_decode;
   logic        valid_decode;

   fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .ir_decode    (ir_decode),
      .pc_decode    (pc_decode),
      .valid_decode (valid_decode)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          have_exp = 0;
   bit          pc_known = 0;
   bit          data_is_addr = 0;
   logic [31:0] e_ir = NOP;
   logic [31:0] e_pcd = '0;
   logic        e_v = 1'b0;
   logic [31:0] e_pc = RST_PC;
   logic [63:0] q[$];
   bit          o_val = 0;
   bit          o_drop = 0;
   logic [31:0] o_addr = '0;
   bit          stale = 0;
   bit          pend = 0;
   logic [31:0] p_addr = '0;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] nxt(input logic [31:0] a);
      logic [31:0] lo;
      lo = (a & 32'h7FFF_FFFF) + 32'd4;
      return (a & 32'h8000_0000) | (lo & 32'h7FFF_FFFF);
   endfunction

   task automatic step(
      input bit          r_n,
      input bit          st,
      input bit          rd,
      input logic [31:0] rpc,
      input bit          gn,
      input int          rv_pct
   );
      bit          rv;
      bit          was_stale;
      logic [31:0] rdat;
      @(negedge clk);
      if (have_exp) begin
         chk("ir_decode", ir_decode, e_ir);
         chk("pc_decode", pc_decode, e_pcd);
         chk("valid_decode", 32'(valid_decode), 32'(e_v));
      end
      rv = 0;
      was_stale = 0;
      rdat = $urandom;
      if (r_n && stale) begin
         rv = 1;
         was_stale = 1;
         stale = 0;
      end else if (r_n && o_val
                   && int'($urandom_range(99)) < rv_pct) begin
         rv = 1;
         if (data_is_addr) rdat = o_addr;
      end
      rst_n       = r_n;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_gnt    = gn;
      imem_rvalid = rv;
      imem_rdata  = rdat;
      #1;
      if (!r_n) begin
         chk("rst_req", 32'(imem_req), 0);
         e_ir = NOP;
         e_pcd = '0;
         e_v = 0;
         q.delete();
         e_pc = RST_PC;
         pc_known = 1;
         if (o_val) stale = 1;
         o_val = 0;
         pend = 0;
      end else begin
         if (pc_known) chk("imem_addr", imem_addr, e_pc);
         if (rv && !was_stale) begin
            if (!o_drop && !rd) begin
               chk("hold_overlap", 32'(q.size()), 0);
               q.push_back({rdat, nxt(o_addr)});
            end
            o_val = 0;
         end
         if (pend && !rd) begin
            chk("req_held", 32'(imem_req), 1);
            chk("addr_held", imem_addr, p_addr);
         end
         if (st && !pend && !rd)
            chk("stall_req", 32'(imem_req), 0);
         if (rd) begin
            chk("redir_req", 32'(imem_req), 0);
            q.delete();
            e_ir = NOP;
            e_pcd = '0;
            e_v = 0;
            if (o_val) o_drop = 1;
            e_pc = rpc & 32'hFFFF_FFFC;
         end else if (!st) begin
            if (q.size() > 0) begin
               {e_ir, e_pcd} = q.pop_front();
               e_v = 1;
            end else begin
               e_ir = NOP;
               e_pcd = '0;
               e_v = 0;
            end
         end
         if (imem_req && gn) begin
            chk("one_outstanding", 32'(o_val), 0);
            o_val = 1;
            o_drop = 0;
            o_addr = imem_addr;
            e_pc = nxt(e_pc);
         end
         pend = imem_req & ~gn;
         p_addr = imem_addr;
      end
      have_exp = 1;
   endtask

   task automatic run(
      input int n,
      input int gn_pct,
      input int rv_pct,
      input int st_pct
   );
      for (int i = 0; i < n; i++)
         step(1, int'($urandom_range(99)) < st_pct, 0, '0,
              int'($urandom_range(99)) < gn_pct, rv_pct);
   endtask

   initial begin
      data_is_addr = 1;
      repeat (3) step(0, 0, 0, '0, 0, 0);
      run(20, 100, 100, 0);
      repeat (3) step(1, 1, 0, '0, 1, 100);
      run(8, 100, 100, 0);
      data_is_addr = 0;
      step(1, 0, 0, '0, 0, 100);
      step(1, 0, 0, '0, 1, 0);
      step(1, 0, 1, 32'h0000_0103, 1, 0);
      step(1, 0, 0, '0, 1, 100);
      run(6, 100, 100, 0);
      step(1, 1, 0, '0, 1, 100);
      step(1, 1, 1, 32'h0000_2000, 1, 100);
      run(6, 100, 100, 0);
      step(1, 0, 0, '0, 1, 100);
      for (int i = 0; i < 4; i++)
         step(1, i[0], 0, '0, 0, 100);
      run(6, 100, 100, 0);
      step(1, 0, 1, 32'h7FFF_FFFC, 1, 100);
      run(6, 100, 100, 0);
      step(1, 0, 1, 32'hFFFF_FFFF, 1, 100);
      run(6, 100, 100, 0);
      step(1, 0, 0, '0, 0, 100);
      step(1, 0, 0, '0, 1, 0);
      repeat (2) step(0, 0, 0, '0, 1, 0);
      run(10, 100, 100, 0);
      for (int i = 0; i < 3000; i++)
         step(int'($urandom_range(199)) != 0,
              int'($urandom_range(99)) < 20,
              int'($urandom_range(99)) < 5,
              $urandom,
              int'($urandom_range(99)) < 60,
              50);
      step(1, 0, 0, '0, 0, 100);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
